// File: rtl/lzc_pkg.sv
// Shared definitions for the sequential leading/trailing zero counter.
package lzc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } lzc_state_t;

  // Count width that can hold 0..w inclusive.
  function automatic int cw_of(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/lzc_slice.sv
// Combinational zero detect and in-slice zero count for one SLICE-bit slice.
// dir=0 counts leading zeros (from MSB), dir=1 counts trailing zeros (from LSB).
module lzc_slice #(
  parameter int SLICE = 8,
  parameter int SW    = $clog2(SLICE)
) (
  input  logic [SLICE-1:0] s,
  input  logic             dir,
  output logic             nz,
  output logic [SW-1:0]    cnt
);

  logic [SW-1:0] lz, tzc;

  // Priority scans: ascending overwrite keeps the highest set bit for lz,
  // descending overwrite keeps the lowest set bit for tz.
  always_comb begin
    lz  = '0;
    tzc = '0;
    for (int i = 0; i < SLICE; i++)
      if (s[i]) lz = SW'(SLICE - 1 - i);
    for (int i = SLICE - 1; i >= 0; i--)
      if (s[i]) tzc = SW'(i);
  end

  assign nz  = |s;
  assign cnt = dir ? tzc : lz;

endmodule

// File: rtl/lzc_zero_seq.sv
// Multi-cycle zero detector / CLZ / CTZ. Scans one SLICE-bit slice per clock
// with a start/busy/done handshake.
// Optional: define LZC_FAST_ZERO_EN to finish an all-zero operand after one
// scan edge using a full-width OR-reduction at accept time.
module lzc_zero_seq
  import lzc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int CW    = cw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tz,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [CW-1:0]    cnt
);

  localparam int N  = WIDTH / SLICE;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N + 1);
  localparam int SW = $clog2(SLICE);

  lzc_state_t                state, state_d;
  logic [N-1:0][SLICE-1:0]   opnd, opnd_d;
  logic                      mode, mode_d;
  logic [PW-1:0]             ptr, ptr_d;
  logic [KW-1:0]             k, k_d;
  logic                      done_d, zero_d;
  logic [CW-1:0]             cnt_d;
  logic                      fast_hit;

  logic                      sl_nz;
  logic [SW-1:0]             sl_cnt;
  logic [CW-1:0]             base;

  // Single slice evaluator, fed by the slice the pointer selects.
  lzc_slice #(.SLICE(SLICE), .SW(SW)) u_slice (
    .s   (opnd[ptr]),
    .dir (mode),
    .nz  (sl_nz),
    .cnt (sl_cnt)
  );

  // Zeros contributed by the k-1 all-zero slices already passed.
  assign base = CW'(k - 1'b1) * CW'(SLICE);

`ifdef LZC_FAST_ZERO_EN
  logic fast, fast_d;
  assign fast_hit = fast;

  // Forced-terminal flag, captured with the operand.
  always_ff @(posedge clk) begin
    if (!rst_n) fast <= 1'b0;
    else        fast <= fast_d;
  end

  // Full-width zero check only evaluated when a request is accepted.
  always_comb begin
    fast_d = fast;
    if (state == ST_IDLE && start) fast_d = ~|A;
  end
`else
  assign fast_hit = 1'b0;
`endif

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      opnd  <= '0;
      mode  <= 1'b0;
      ptr   <= '0;
      k     <= '0;
      done  <= 1'b0;
      zero  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      opnd  <= opnd_d;
      mode  <= mode_d;
      ptr   <= ptr_d;
      k     <= k_d;
      done  <= done_d;
      zero  <= zero_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state: accept in IDLE, walk slices in SCAN until a nonzero slice
  // or the last slice. Results hold until the next completion.
  always_comb begin
    state_d = state;
    opnd_d  = opnd;
    mode_d  = mode;
    ptr_d   = ptr;
    k_d     = k;
    done_d  = 1'b0;
    zero_d  = zero;
    cnt_d   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          opnd_d  = A;
          mode_d  = tz;
          ptr_d   = tz ? PW'(0) : PW'(N - 1);
          k_d     = KW'(1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (fast_hit || (!sl_nz && k == KW'(N))) begin
          zero_d  = 1'b1;
          cnt_d   = CW'(WIDTH);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (sl_nz) begin
          zero_d  = 1'b0;
          cnt_d   = base + CW'(sl_cnt);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ptr_d = mode ? ptr + 1'b1 : ptr - 1'b1;
          k_d   = k + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SCAN);

endmodule

// File: tb/tb_lzc_zero_seq.sv
// Directed bench for lzc_zero_seq (WIDTH=32, SLICE=8).
module tb_lzc_zero_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, tz;
  logic [31:0] A;
  logic        busy, done, zero;
  logic [5:0]  cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [5:0] prev_cnt;

  lzc_zero_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tz(tz), .A(A),
    .busy(busy), .done(done), .zero(zero), .cnt(cnt)
  );

  always #5 clk = ~clk;

`ifdef LZC_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 4;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Drive a request at the next edge (E0), then count edges until done.
  task automatic run_op(input string tag, input logic [31:0] a, input logic m,
                        input int lat, input logic ez, input logic [5:0] ec);
    int cyc;
    cyc = 0;
    start = 1'b1; A = a; tz = m;
    @(posedge clk); #1;
    start = 1'b0; A = '0; tz = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_hold"}, cnt, prev_cnt);
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_zero"}, zero, ez);
    chk({tag, "_cnt"}, cnt, ec);
    chk({tag, "_idle"}, busy, 0);
    prev_cnt = ec;
  endtask

  initial begin
    int cyc;
    logic seen;
    rst_n = 1'b0; start = 1'b0; tz = 1'b0; A = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_cnt",  cnt, 0);
    prev_cnt = 6'd0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("lz_mid",   32'h0001_0000, 1'b0, 2,    1'b0, 6'd15);
    run_op("lz_zero",  32'h0000_0000, 1'b0, ZLAT, 1'b1, 6'd32);
    run_op("lz_msb",   32'h8000_0000, 1'b0, 1,    1'b0, 6'd0);
    run_op("tz_msb",   32'h8000_0000, 1'b1, 4,    1'b0, 6'd31);
    run_op("tz_zero",  32'h0000_0000, 1'b1, ZLAT, 1'b1, 6'd32);
    run_op("tz_s2",    32'h00F0_0000, 1'b1, 3,    1'b0, 6'd20);
    run_op("tz_s1",    32'h0000_0100, 1'b1, 2,    1'b0, 6'd8);
    // Issued in the done cycle of the previous op: back-to-back accept.
    run_op("b2b",      32'h0000_0001, 1'b1, 1,    1'b0, 6'd0);

    // Second start during the scan must be ignored.
    start = 1'b1; A = 32'h0000_0001; tz = 1'b0;
    @(posedge clk); #1;            // E0
    start = 1'b0;
    @(posedge clk); #1;            // E1
    start = 1'b1; A = 32'hFFFF_FFFF;
    @(posedge clk); #1;            // E2
    start = 1'b0; A = '0;
    chk("ign_busy", busy, 1);
    cyc = 2;
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ign_lat",  cyc, 4);
    chk("ign_cnt",  cnt, 31);
    chk("ign_zero", zero, 0);
    @(posedge clk); #1;
    chk("ign_pulse", done, 0);
    chk("ign_idle",  busy, 0);

    // Reset in the middle of a scan.
    start = 1'b1; A = 32'h0000_0001; tz = 1'b0;
    @(posedge clk); #1;            // E0
    start = 1'b0; A = '0;
    @(posedge clk); #1;            // E1
    rst_n = 1'b0;
    @(posedge clk); #1;            // E2
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_zero", zero, 0);
    chk("mrst_cnt",  cnt, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("mrst_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
